// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, op codes and state type for the multi-word ALU sequencer
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_BMA = 3'b001;
  localparam logic [2:0] OP_AMB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_SET = 3'b111;

  // S_CAPT is only reachable when the ALU outputs are registered
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CAPT = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_BMA) || (op == OP_AMB) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/alu_multiword_seq_if.sv
// rtl/alu_multiword_seq_if.sv - request, ALU and response signal bundle of the multi-word sequencer
interface alu_multiword_seq_if #(
  parameter int W         = 32,
  parameter int MAX_WORDS = 4,
  parameter int NW_BITS   = 2
);
  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             req_op;
  logic [NW_BITS-1:0]     req_nwords;
  logic [W*MAX_WORDS-1:0] req_a;
  logic [W*MAX_WORDS-1:0] req_b;

  logic [W-1:0]           alu_a;
  logic [W-1:0]           alu_b;
  logic [2:0]             alu_s;
  logic                   alu_cin;
  logic [W-1:0]           alu_f;
  logic                   alu_cout;
  logic                   alu_ovf;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [W*MAX_WORDS-1:0] rsp_f;
  logic                   rsp_cout;
  logic                   rsp_ovf;
  logic                   rsp_zero;
  logic                   rsp_neg;

  modport slave (
    input  req_valid, req_op, req_nwords, req_a, req_b,
    output req_ready,
    output alu_a, alu_b, alu_s, alu_cin,
    input  alu_f, alu_cout, alu_ovf,
    output rsp_valid, rsp_f, rsp_cout, rsp_ovf, rsp_zero, rsp_neg,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_nwords, req_a, req_b,
    input  req_ready,
    input  alu_a, alu_b, alu_s, alu_cin,
    output alu_f, alu_cout, alu_ovf,
    input  rsp_valid, rsp_f, rsp_cout, rsp_ovf, rsp_zero, rsp_neg,
    output rsp_ready
  );
endinterface

// File: rtl/alu_word_mux.sv
// rtl/alu_word_mux.sv - selects one W-bit word out of a packed multi-word operand
module alu_word_mux #(
  parameter int W         = 32,
  parameter int MAX_WORDS = 4,
  parameter int NW_BITS   = 2
) (
  input  logic [W*MAX_WORDS-1:0] data,
  input  logic [NW_BITS-1:0]     idx,
  output logic [W-1:0]           sel_word
);

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (idx == NW_BITS'(k)) sel_word = data[k*W +: W];
    end
  end

endmodule

// File: rtl/alu_multiword_seq.sv
// rtl/alu_multiword_seq.sv - multi-word sequencer around a 74381-style ALU; ALU_PIPE_EN registers ALU outputs
module alu_multiword_seq
  import alu_pkg::*;
#(
  parameter int MAX_WORDS = 4,
  parameter int NW_BITS   = 2
) (
  input logic               clk,
  input logic               rst,
  alu_multiword_seq_if.slave bus
);

  localparam int W  = ALU_W;
  localparam int TW = W * MAX_WORDS;

  seq_state_t         state_q, state_d;
  logic [2:0]         op_q;
  logic [NW_BITS-1:0] nw_q;
  logic [NW_BITS-1:0] idx_q;
  logic [TW-1:0]      a_q, b_q, f_q;
  logic               carry_q, cout_q, ovf_q, zacc_q, zero_q, neg_q;

  logic [W-1:0]       word_a, word_b;
  logic               accept, last, in_run, cap_en, arith, cin_word;
  logic [W-1:0]       cap_f;
  logic               cap_cout, cap_ovf;

  alu_word_mux #(.W(W), .MAX_WORDS(MAX_WORDS), .NW_BITS(NW_BITS)) u_mux_a (
    .data     (a_q),
    .idx      (idx_q),
    .sel_word (word_a)
  );

  alu_word_mux #(.W(W), .MAX_WORDS(MAX_WORDS), .NW_BITS(NW_BITS)) u_mux_b (
    .data     (b_q),
    .idx      (idx_q),
    .sel_word (word_b)
  );

  assign accept = bus.req_valid && (state_q == S_IDLE);
  assign last   = (idx_q == nw_q);
  assign in_run = (state_q == S_RUN) || (state_q == S_CAPT);
  assign arith  = is_arith(op_q);

  // Word 0 seeds the chain: subtracts need +1 to complete the two's complement
  assign cin_word = arith && ((idx_q == '0) ? (op_q != OP_ADD) : carry_q);

`ifdef ALU_PIPE_EN
  logic [W-1:0] pf_q;
  logic         pc_q, po_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_q <= '0;
      pc_q <= 1'b0;
      po_q <= 1'b0;
    end else begin
      pf_q <= bus.alu_f;
      pc_q <= bus.alu_cout;
      po_q <= bus.alu_ovf;
    end
  end

  assign cap_en   = (state_q == S_CAPT);
  assign cap_f    = pf_q;
  assign cap_cout = pc_q;
  assign cap_ovf  = po_q;
`else
  assign cap_en   = (state_q == S_RUN);
  assign cap_f    = bus.alu_f;
  assign cap_cout = bus.alu_cout;
  assign cap_ovf  = bus.alu_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_s     = OP_CLR;
    bus.alu_cin   = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = S_RUN;
      end
      S_RUN: begin
`ifdef ALU_PIPE_EN
        state_d = S_CAPT;
`else
        if (last) state_d = S_DONE;
`endif
      end
      S_CAPT: begin
        state_d = last ? S_DONE : S_RUN;
      end
      S_DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (in_run) begin
      bus.alu_a   = word_a;
      bus.alu_b   = word_b;
      bus.alu_s   = op_q;
      bus.alu_cin = cin_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_CLR;
      nw_q    <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zacc_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= bus.req_op;
      nw_q    <= bus.req_nwords;
      idx_q   <= '0;
      a_q     <= bus.req_a;
      b_q     <= bus.req_b;
      f_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zacc_q  <= 1'b1;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else if (cap_en) begin
      for (int k = 0; k < MAX_WORDS; k++) begin
        if (idx_q == NW_BITS'(k)) f_q[k*W +: W] <= cap_f;
      end
      carry_q <= cap_cout;
      zacc_q  <= zacc_q && (cap_f == '0);
      // Flags are published only once the final word lands so DONE sees a coherent set
      if (last) begin
        cout_q <= arith && cap_cout;
        ovf_q  <= arith && cap_ovf;
        zero_q <= zacc_q && (cap_f == '0);
        neg_q  <= cap_f[W-1];
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign bus.rsp_f    = f_q;
  assign bus.rsp_cout = cout_q;
  assign bus.rsp_ovf  = ovf_q;
  assign bus.rsp_zero = zero_q;
  assign bus.rsp_neg  = neg_q;

endmodule

// File: tb/tb_alu_multiword_seq.sv
// tb/tb_alu_multiword_seq.sv - directed self-checking bench with a behavioural 74381 ALU model
module tb_alu_multiword_seq;

`ifdef ALU_PIPE_EN
  localparam int CPW = 2;
`else
  localparam int CPW = 1;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_multiword_seq_if bus ();

  alu_multiword_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 74381 model: subtracts are A + ~B + cin, carry out is "no borrow"
  logic [32:0] m_sum;
  always_comb begin
    m_sum        = '0;
    bus.alu_f    = '0;
    bus.alu_cout = 1'b0;
    bus.alu_ovf  = 1'b0;
    case (bus.alu_s)
      3'b001: begin
        m_sum        = {1'b0, bus.alu_b} + {1'b0, ~bus.alu_a} + {32'd0, bus.alu_cin};
        bus.alu_f    = m_sum[31:0];
        bus.alu_cout = m_sum[32];
        bus.alu_ovf  = (bus.alu_b[31] != bus.alu_a[31]) && (m_sum[31] != bus.alu_b[31]);
      end
      3'b010: begin
        m_sum        = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {32'd0, bus.alu_cin};
        bus.alu_f    = m_sum[31:0];
        bus.alu_cout = m_sum[32];
        bus.alu_ovf  = (bus.alu_a[31] != bus.alu_b[31]) && (m_sum[31] != bus.alu_a[31]);
      end
      3'b011: begin
        m_sum        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {32'd0, bus.alu_cin};
        bus.alu_f    = m_sum[31:0];
        bus.alu_cout = m_sum[32];
        bus.alu_ovf  = (bus.alu_a[31] == bus.alu_b[31]) && (m_sum[31] != bus.alu_a[31]);
      end
      3'b100: bus.alu_f = bus.alu_a ^ bus.alu_b;
      3'b101: bus.alu_f = bus.alu_a | bus.alu_b;
      3'b110: bus.alu_f = bus.alu_a & bus.alu_b;
      3'b111: bus.alu_f = 32'hFFFF_FFFF;
      default: bus.alu_f = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic [2:0] op, input logic [1:0] nw,
                        input logic [127:0] a, input logic [127:0] b,
                        input logic [127:0] ef, input logic ec, input logic eo,
                        input logic ez, input logic en, input logic [3:0] ecin,
                        input int hold);
    logic [127:0] f0;
    int           waited;
    @(negedge clk);
    chk({tag, " req_ready idle"}, 128'(bus.req_ready), 128'd1);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_nwords = nw;
    bus.req_a      = a;
    bus.req_b      = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int c = 0; c < (int'(nw) + 1) * CPW; c++) begin
      @(negedge clk);
      if (c % CPW == 0) begin
        chk({tag, " alu_cin"}, 128'(bus.alu_cin), 128'(ecin[c / CPW]));
        chk({tag, " alu_s"}, 128'(bus.alu_s), 128'(op));
        chk({tag, " alu_a"}, 128'(bus.alu_a), 128'(a[(c / CPW) * 32 +: 32]));
        chk({tag, " alu_b"}, 128'(bus.alu_b), 128'(b[(c / CPW) * 32 +: 32]));
        chk({tag, " busy rsp_valid"}, 128'(bus.rsp_valid), 128'd0);
      end
    end
    @(negedge clk);
    chk({tag, " latency rsp_valid"}, 128'(bus.rsp_valid), 128'd1);
    waited = 0;
    while (bus.rsp_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, " rsp_f"}, bus.rsp_f, ef);
    chk({tag, " rsp_cout"}, 128'(bus.rsp_cout), 128'(ec));
    chk({tag, " rsp_ovf"}, 128'(bus.rsp_ovf), 128'(eo));
    chk({tag, " rsp_zero"}, 128'(bus.rsp_zero), 128'(ez));
    chk({tag, " rsp_neg"}, 128'(bus.rsp_neg), 128'(en));
    chk({tag, " done alu_s"}, 128'(bus.alu_s), 128'd0);
    f0 = ef;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold rsp_valid"}, 128'(bus.rsp_valid), 128'd1);
      chk({tag, " hold req_ready"}, 128'(bus.req_ready), 128'd0);
      chk({tag, " hold rsp_f"}, bus.rsp_f, f0);
      chk({tag, " hold rsp_cout"}, 128'(bus.rsp_cout), 128'(ec));
      chk({tag, " hold rsp_zero"}, 128'(bus.rsp_zero), 128'(ez));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk({tag, " post req_ready"}, 128'(bus.req_ready), 128'd1);
    chk({tag, " post rsp_valid"}, 128'(bus.rsp_valid), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'b000;
    bus.req_nwords = 2'd0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("reset req_ready", 128'(bus.req_ready), 128'd1);
    chk("reset rsp_valid", 128'(bus.rsp_valid), 128'd0);
    chk("reset alu_s", 128'(bus.alu_s), 128'd0);
    chk("reset alu_a", 128'(bus.alu_a), 128'd0);
    chk("reset alu_cin", 128'(bus.alu_cin), 128'd0);
    chk("reset rsp_f", bus.rsp_f, 128'd0);
    chk("reset rsp_zero", 128'(bus.rsp_zero), 128'd0);
    chk("reset rsp_cout", 128'(bus.rsp_cout), 128'd0);
    rst = 1'b0;

    do_req("add1", 3'b011, 2'd0, 128'h1, 128'h2,
           128'h3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0);

    do_req("add2", 3'b011, 2'd1, 128'h0000_0000_FFFF_FFFF, 128'h1,
           128'h1_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 0);

    do_req("amb4", 3'b010, 2'd3, 128'h5, 128'h5,
           128'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 0);

    do_req("xor3", 3'b100, 2'd2,
           128'hFFFF_FFFF_1234_5678_9ABC_DEF0_0BAD_F00D,
           128'h0000_0000_1234_5678_9ABC_DEF0_0BAD_F00D,
           128'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 0);

    do_req("bma_hold", 3'b001, 2'd0, 128'h2, 128'h1,
           128'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 5);

    do_req("add_ovf", 3'b011, 2'd0, 128'h7FFF_FFFF, 128'h1,
           128'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 0);

    do_req("or2", 3'b101, 2'd1, 128'h0000_0000_0000_00F0, 128'h0000_000F_0000_0000,
           128'h0000_000F_0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0);

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = 3'b011;
    bus.req_nwords = 2'd3;
    bus.req_a      = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    bus.req_b      = 128'h1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort rsp_valid", 128'(bus.rsp_valid), 128'd0);
    chk("abort alu_s", 128'(bus.alu_s), 128'd0);
    chk("abort alu_a", 128'(bus.alu_a), 128'd0);
    chk("abort req_ready", 128'(bus.req_ready), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort idle rsp_valid", 128'(bus.rsp_valid), 128'd0);

    do_req("add4_after_rst", 3'b011, 2'd3,
           128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1,
           128'h0000_0001_0000_0000_0000_0000_0000_0000,
           1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
